music_box_mode_controller: RTL

MUSIC_BOX_MODE_CONTROLLER -- requirements
Module: music_box_mode_controller

---
 rtl/musicbox_pkg.sv | 23 ++
 rtl/sdram_request_port.sv | 56 +++++
 rtl/music_box_mode_controller.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/musicbox_pkg.sv
`default_nettype none
// ============================================================================
// Module      : musicbox_pkg
// Description : Shared mode encoding and datapath widths for the music box.
// Revision    : 1.0 - initial release
// ============================================================================
package musicbox_pkg;

    localparam int c_ADDR_WIDTH   = 24;
    localparam int c_SAMPLE_WIDTH = 16;

    // Encoding is visible on currentMode, so values are fixed.
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PLAY_SONG0 = 3'd1,
        PLAY_SONG1 = 3'd2,
        RECORD     = 3'd3,
        PLAY_REC   = 3'd4,
        DRAIN      = 3'd5
    } musicState_t;

endpackage
`default_nettype wire

// File: rtl/sdram_request_port.sv
`default_nettype none
// ============================================================================
// Module      : sdram_request_port
// Description : Single-outstanding SDRAM request holder; fields stay frozen
//               from issue through the acknowledging cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_request_port
    import musicbox_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_issue,
    input  logic                      i_write,
    input  logic [c_ADDR_WIDTH-1:0]   i_address,
    input  logic [c_SAMPLE_WIDTH-1:0] i_writeData,
    input  logic                      i_ack,
    output logic                      o_req,
    output logic                      o_write,
    output logic [c_ADDR_WIDTH-1:0]   o_address,
    output logic [c_SAMPLE_WIDTH-1:0] o_writeData,
    output logic                      o_ackSeen
);

    logic                      r_req;
    logic                      r_write;
    logic [c_ADDR_WIDTH-1:0]   r_address;
    logic [c_SAMPLE_WIDTH-1:0] r_writeData;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req       <= 1'b0;
            r_write     <= 1'b0;
            r_address   <= '0;
            r_writeData <= '0;
        end else if (r_req) begin
            if (i_ack) begin
                r_req <= 1'b0;
            end
        end else if (i_issue) begin
            r_req       <= 1'b1;
            r_write     <= i_write;
            r_address   <= i_address;
            r_writeData <= i_writeData;
        end
    end

    // Stray acks with nothing outstanding never reach the controller.
    assign o_ackSeen   = r_req & i_ack;
    assign o_req       = r_req;
    assign o_write     = r_write;
    assign o_address   = r_address;
    assign o_writeData = r_writeData;

endmodule
`default_nettype wire

// File: rtl/music_box_mode_controller.sv
`default_nettype none
// ============================================================================
// Module      : music_box_mode_controller
// Description : Mode FSM for song playback, sample recording to SDRAM and
//               playback of the recording.
// Revision    : 1.0 - initial release
// ============================================================================
module music_box_mode_controller
    import musicbox_pkg::*;
#(
    parameter int unsigned MAX_RECORD_WORDS = 1323000
)(
    input  logic                      max10Board_50MhzClock,
    input  logic                      reset,
    input  logic                      sampleTick,
    input  logic                      pressPlaySong0,
    input  logic                      pressPlaySong1,
    input  logic                      pressMakeRecording,
    input  logic                      pressPlayRecording,
    input  logic                      songDone,
    input  logic [c_SAMPLE_WIDTH-1:0] synthSample,
    output logic                      sdramReq,
    output logic                      sdramWrite,
    output logic [c_ADDR_WIDTH-1:0]   sdramAddress,
    output logic [c_SAMPLE_WIDTH-1:0] sdramWriteData,
    input  logic                      sdramAck,
    input  logic [c_SAMPLE_WIDTH-1:0] sdramReadData,
    output logic [2:0]                currentMode,
    output logic [c_SAMPLE_WIDTH-1:0] playbackSample,
    output logic [c_ADDR_WIDTH-1:0]   recordingLength,
    output logic                      overrunError
);

    localparam logic [c_ADDR_WIDTH-1:0] c_MAX_WORDS = c_ADDR_WIDTH'(MAX_RECORD_WORDS);
    localparam logic [c_ADDR_WIDTH-1:0] c_ONE       = c_ADDR_WIDTH'(1);

    musicState_t               r_state;
    logic [c_ADDR_WIDTH-1:0]   r_addrCounter;
    logic [c_ADDR_WIDTH-1:0]   r_recordingLength;
    logic [c_SAMPLE_WIDTH-1:0] r_playbackSample;
    logic                      r_overrunError;

    logic w_ackSeen;
    logic w_issue;
    logic w_issueWrite;
    logic w_pending;
    logic w_recordStop;
    logic w_lastRead;
    logic w_tickWhileBusy;

    // Outstanding means it will still be outstanding after this edge.
    assign w_pending       = sdramReq & ~w_ackSeen;
    assign w_recordStop    = pressMakeRecording | (r_addrCounter == c_MAX_WORDS);
    assign w_lastRead      = (r_addrCounter == (r_recordingLength - c_ONE));
    assign w_issueWrite    = (r_state == RECORD);
    assign w_tickWhileBusy = sampleTick & sdramReq &
                             ((r_state == RECORD) | (r_state == PLAY_REC));
    assign w_issue         = sampleTick & ~sdramReq &
                             (((r_state == RECORD)   & ~w_recordStop) |
                              ((r_state == PLAY_REC) & ~pressPlayRecording));

    sdram_request_port u_requestPort (
        .clk         (max10Board_50MhzClock),
        .rst         (reset),
        .i_issue     (w_issue),
        .i_write     (w_issueWrite),
        .i_address   (r_addrCounter),
        .i_writeData (synthSample),
        .i_ack       (sdramAck),
        .o_req       (sdramReq),
        .o_write     (sdramWrite),
        .o_address   (sdramAddress),
        .o_writeData (sdramWriteData),
        .o_ackSeen   (w_ackSeen)
    );

    always_ff @(posedge max10Board_50MhzClock) begin
        if (reset) begin
            r_state           <= IDLE;
            r_addrCounter     <= '0;
            r_recordingLength <= '0;
            r_playbackSample  <= '0;
            r_overrunError    <= 1'b0;
        end else begin
            if (w_tickWhileBusy) begin
                r_overrunError <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (pressMakeRecording) begin
                        r_state           <= RECORD;
                        r_addrCounter     <= '0;
                        r_recordingLength <= '0;
                    end else if (pressPlayRecording && (r_recordingLength != '0)) begin
                        r_state       <= PLAY_REC;
                        r_addrCounter <= '0;
                    end else if (pressPlaySong0) begin
                        r_state <= PLAY_SONG0;
                    end else if (pressPlaySong1) begin
                        r_state <= PLAY_SONG1;
                    end
                end
                PLAY_SONG0: begin
                    if (songDone || pressPlaySong0) begin
                        r_state <= IDLE;
                    end
                end
                PLAY_SONG1: begin
                    if (songDone || pressPlaySong1) begin
                        r_state <= IDLE;
                    end
                end
                RECORD: begin
                    if (w_ackSeen) begin
                        r_addrCounter     <= r_addrCounter + c_ONE;
                        r_recordingLength <= r_recordingLength + c_ONE;
                    end
                    if (w_recordStop) begin
                        r_state <= w_pending ? DRAIN : IDLE;
                    end
                end
                PLAY_REC: begin
                    if (w_ackSeen) begin
                        r_addrCounter <= r_addrCounter + c_ONE;
                        if (w_lastRead || pressPlayRecording) begin
                            r_state          <= IDLE;
                            r_playbackSample <= '0;
                        end else begin
                            r_playbackSample <= sdramReadData;
                        end
                    end else if (pressPlayRecording) begin
                        r_state          <= sdramReq ? DRAIN : IDLE;
                        r_playbackSample <= '0;
                    end
                end
                DRAIN: begin
                    if (w_ackSeen) begin
                        r_addrCounter <= r_addrCounter + c_ONE;
                        if (sdramWrite) begin
                            r_recordingLength <= r_recordingLength + c_ONE;
                        end
                        r_state <= IDLE;
                    end else if (!sdramReq) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign currentMode     = r_state;
    assign playbackSample  = r_playbackSample;
    assign recordingLength = r_recordingLength;
    assign overrunError    = r_overrunError;

endmodule
`default_nettype wire
